// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register scoreboard that stalls decode on RAW/WAW hazards
//
// Tracks which of the NUM_REGS architectural registers have a write in flight.
// An instruction is held in decode while any register it reads or writes is
// still pending. Writeback clears the bit, and there is no bypass path.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   issue_*          instruction presented by decode (valid, rs1/rs2/rd, use flags, we)
//   issue_stall      combinational hold for decode
//   issue_accept     combinational issue indication
//   wb_valid, wb_rd  writeback commit strobe and destination register
//   flush            discard every in-flight write
//   pending_mask     registered in-flight bitmap
//   pending_count    registered popcount of pending_mask
//   stall_cycles     registered saturating count of stalled cycles
//   wb_err           registered sticky flag for writeback to a non-pending register
module reg_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rs1,
  input  logic [ADDR_W-1:0]   issue_rs2,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                issue_use_rs1,
  input  logic                issue_use_rs2,
  input  logic                issue_we,
  output logic                issue_stall,
  output logic                issue_accept,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd,
  input  logic                flush,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [ADDR_W:0]     pending_count,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic                wb_err
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic                err_q, err_d;
  logic                haz;

  // Hazards look only at the registered mask. A writeback in this same cycle
  // does not unblock the instruction until the next cycle.
  assign haz = (issue_use_rs1 & pend_q[issue_rs1]) |
               (issue_use_rs2 & pend_q[issue_rs2]) |
               (issue_we      & pend_q[issue_rd]);

  assign issue_stall  = issue_valid & (haz | flush);
  assign issue_accept = issue_valid & ~issue_stall;

  always_comb begin
    pend_d = pend_q;
    if (flush) begin
      pend_d = '0;
    end else begin
      if (wb_valid) pend_d[wb_rd] = 1'b0;
      // The set is applied after the clear, so it wins if both hit the same index.
      if (issue_accept && issue_we) pend_d[issue_rd] = 1'b1;
    end

    // The count is taken from the next mask, so count and mask update together.
    cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
    end

    stall_d = stall_q;
    if (issue_stall && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_ONE;

    err_d = err_q | (wb_valid & ~flush & ~pend_q[wb_rd]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      cnt_q   <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign pending_mask  = pend_q;
  assign pending_count = cnt_q;
  assign stall_cycles  = stall_q;
  assign wb_err        = err_q;

endmodule
